// File: rtl/ex_result_mdu.sv
// Execute-stage result unit: multi-cycle mult/div engine, HI/LO registers and EX result select.
// Optional abort of in-flight operations is compiled in with `define MDU_CANCEL_EN.
module ex_result_mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic [2:0]       md_op,
   input  logic             start,
   input  logic [1:0]       res_sel,
`ifdef MDU_CANCEL_EN
   input  logic             cancel,
`endif
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CntW      = $clog2(MaxCycles + 1);

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } mdOpT;

   logic [CntW-1:0]    count;
   mdOpT               opReg;
   logic [WIDTH-1:0]   opA, opB;
   logic               cancelHit;
   logic               doneWrite;
   logic [WIDTH-1:0]   hiDone, loDone;
   logic [2*WIDTH-1:0] prodS, prodU;
   logic               negA, negB;
   logic [WIDTH-1:0]   magA, magB, safeB, quotMag, remMag;

`ifdef MDU_CANCEL_EN
   assign cancelHit = cancel;
`else
   assign cancelHit = 1'b0;
`endif

   assign busy = (count != '0);

   // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
   assign prodU = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
   assign prodS = {{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opB[WIDTH-1]}}, opB};

   // Signed division via magnitudes: MIN / -1 falls out as MIN with remainder 0.
   assign negA    = (opReg == MD_DIV) && opA[WIDTH-1];
   assign negB    = (opReg == MD_DIV) && opB[WIDTH-1];
   assign magA    = negA ? -opA : opA;
   assign magB    = negB ? -opB : opB;
   assign safeB   = (opB == '0) ? WIDTH'(1) : magB;
   assign quotMag = magA / safeB;
   assign remMag  = magA % safeB;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      doneWrite = 1'b0;
      hiDone    = hi;
      loDone    = lo;
      case (opReg)
         MD_MULT: begin
            doneWrite = 1'b1;
            {hiDone, loDone} = prodS;
         end
         MD_MULTU: begin
            doneWrite = 1'b1;
            {hiDone, loDone} = prodU;
         end
         MD_DIV, MD_DIVU: begin
            doneWrite = (opB != '0);
            loDone    = (negA ^ negB) ? -quotMag : quotMag;
            hiDone    = negA ? -remMag : remMag;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         count <= '0;
         opReg <= MD_NONE;
         opA   <= '0;
         opB   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (busy) begin
         if (cancelHit) begin
            count <= '0;
         end else if (count == CntW'(1)) begin
            count <= '0;
            if (doneWrite) begin
               hi <= hiDone;
               lo <= loDone;
            end
         end else begin
            count <= count - CntW'(1);
         end
      end else if (start && !cancelHit) begin
         case (mdOpT'(md_op))
            MD_MULT, MD_MULTU: begin
               count <= CntW'(MULT_CYCLES);
               opReg <= mdOpT'(md_op);
               opA   <= rs_val;
               opB   <= rt_val;
            end
            MD_DIV, MD_DIVU: begin
               count <= CntW'(DIV_CYCLES);
               opReg <= mdOpT'(md_op);
               opA   <= rs_val;
               opB   <= rt_val;
            end
            MD_MTHI: hi <= rs_val;
            MD_MTLO: lo <= rs_val;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (res_sel)
         2'd1:    result = hi;
         2'd2:    result = lo;
         default: result = alu_result;
      endcase
   end

endmodule

// File: doc/ex_result_mdu.md
Name: ex_result_mdu

Overview:
Parametrised execute-stage result unit. Combines a multi-cycle multiply/divide engine, HI/LO registers and the final execute-stage result selector. Successor to the two-way ALU/MDU result mux: it owns the MDU timing (start/busy), HI/LO state and an N-way result select. It sits in the EX stage, feeding the EX/MEM pipeline register; the hazard unit stalls on `busy`.

Parameters:
WIDTH, 32, datapath width of operands, HI, LO and result.
MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
alu_result  input  WIDTH  ALU output
rs_val  input  WIDTH  operand A (dividend / multiplicand / mthi-mtlo source)
rt_val  input  WIDTH  operand B (divisor / multiplier)
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (= none)
start  input  1  qualifies md_op for one cycle
res_sel  input  2  0 alu_result, 1 HI, 2 LO, 3 alu_result
cancel  input  1  abort in-flight operation (present only with MDU_CANCEL_EN)
busy  output  1  multi-cycle operation in flight
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
result  output  WIDTH  selected EX result

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, counter=0, captured operands=0. Effect is immediate; any in-flight operation is discarded.
- Start acceptance: start=1 && busy=0 accepts md_op at the rising edge. start while busy=1 is ignored entirely. Stalling is the hazard unit's job.
- mult/multu/div/divu:
  - Capture rs_val, rt_val and op at the accept edge T.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from T through the edge T+N, i.e. exactly N cycles high.
  - At edge T+N, HI/LO are written and busy falls in the same edge.
  - Intermediate HI/LO values are never visible.
- mult: {hi,lo} = signed A*B, 2*WIDTH bits. multu: unsigned product.
- div: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign. divu: unsigned quotient and remainder.
- Divisor 0: HI/LO unchanged; busy still runs the full DIV_CYCLES.
- Signed MIN / -1: lo = MIN (wraps), hi = 0.
- mthi/mtlo: single cycle, no busy. At the accept edge, hi (resp. lo) = rs_val.
- md_op 0/7 with start: no effect.
- result is purely combinational from res_sel, alu_result, hi and lo. Selecting HI/LO while busy returns the old value; the stall guarantees correctness.
- Operand inputs may change freely after the accept edge; only captured copies are used.
- Computation may be implemented iteratively or combinationally with a delay counter. Only the cycle-level timing above is normative.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- With the macro defined:
  - The `cancel` port exists.
  - cancel=1 at an edge while busy=1 aborts: busy=0, counter=0, HI/LO unchanged. This holds even on the final edge T+N, where cancel wins.
  - cancel with start in the same cycle: start is ignored.
  - cancel while idle: no effect.
  - Used for exception/interrupt flushes.
- Without the macro: no `cancel` port; in-flight operations always complete.

Test Plan:
1. Reset: drive rst_n=0 mid-operation (busy=1, counter=3) -> hi=0, lo=0, busy=0 immediately without a clock edge; result with res_sel=1 reads 0.
2. mult: start with md_op=1, rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. div: rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then div by 0 with hi/lo preset by mthi/mtlo to 0x11/0x22 -> after 10 cycles still 0x11/0x22. Then 0x80000000 / -1 -> lo=0x80000000, hi=0.
4. Busy interlock: start mult 2*3, then on the next cycle start mtlo rs=0x55 -> mtlo ignored; after completion lo=6, hi=0.
5. Select: res_sel 0/1/2/3 with alu_result=0xA5A5A5A5, hi=0x1, lo=0x2 -> result 0xA5A5A5A5 / 0x1 / 0x2 / 0xA5A5A5A5, same cycle.
6. MDU_CANCEL_EN build: divu 100/7, cancel asserted on the 4th busy cycle -> busy=0 next edge, hi/lo keep prior values. Repeat with cancel on the final busy cycle -> hi/lo unchanged.
